// File: rtl/obi_memory_responder.sv
// obi_memory_responder: OBI slave with a word-addressed memory array and an in-order response FIFO.
module obi_memory_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 1,
  parameter int MEM_DEPTH   = 1024,
  parameter int OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  output logic                    gnt,
  output logic                    gntpar,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [ID_WIDTH-1:0]     aid,
  output logic                    rvalid,
  output logic                    rvalidpar,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [ID_WIDTH-1:0]     rid,
  output logic                    exokay
);
  localparam int BE  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BE);
  localparam int MW  = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam int PW  = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam int CW  = $clog2(OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] mem    [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [OUTSTANDING];
  logic                  q_err  [OUTSTANDING];
  logic [ID_WIDTH-1:0]   q_id   [OUTSTANDING];
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] idx;
  logic [MW-1:0]         midx;
  logic                  in_range, push, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  assign idx       = addr >> OFF;
  assign midx      = idx[MW-1:0];
  assign in_range  = idx < ADDR_WIDTH'(MEM_DEPTH);
  assign gnt       = count < CW'(OUTSTANDING);
  assign gntpar    = ~gnt;
  // Nothing is accepted while reset is held, even with req high.
  assign push      = req & gnt & reset_n;
  assign rvalid    = count != '0;
  assign rvalidpar = ~rvalid;
  assign pop       = rvalid & rready;
  assign rdata     = rvalid ? q_data[rptr] : '0;
  assign err       = rvalid ? q_err[rptr] : 1'b0;
  assign rid       = rvalid ? q_id[rptr] : '0;
  assign exokay    = 1'b0;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= inc(wptr);
      if (pop) rptr <= inc(rptr);
      count <= count + CW'(push) - CW'(pop);
    end

  // Read data samples the array before this edge's write lands.
  always_ff @(posedge clk)
    if (push) begin
      q_data[wptr] <= (~we & in_range) ? mem[midx] : '0;
      q_err[wptr]  <= ~in_range;
      q_id[wptr]   <= aid;
    end

  always_ff @(posedge clk)
    if (push & we & in_range)
      for (int i = 0; i < BE; i++)
        if (be[i]) mem[midx][i*8 +: 8] <= wdata[i*8 +: 8];
endmodule

// File: doc/obi_memory_responder.md
# obi_memory_responder

Synthesizable OBI slave that terminates the OBI memory interface in the role opposite to the core's instruction/data master port. It grants address-phase requests, performs word-wide reads and byte-enabled writes into an internal memory array, and returns in-order responses through a response FIFO with full `rvalid`/`rready` back-pressure. It sits in the testbench/SoC fabric as the memory endpoint behind the OBI agent's passive monitor.

## Interface
- `ADDR_WIDTH`, 32, width of `addr`.
- `DATA_WIDTH`, 32, width of `wdata`/`rdata`; only 32 and 64 are legal; `be` width is `DATA_WIDTH/8`.
- `ID_WIDTH`, 1, width of `aid`/`rid`.
- `MEM_DEPTH`, 1024, number of `DATA_WIDTH` words in the array.
- `OUTSTANDING`, 2, response FIFO depth, and the maximum number of accepted, not-yet-retired transactions; legal values are 1 to 8.

- `clk`  in  1  bus clock; all transfers sample on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  address-phase request.
- `gnt`  out  1  address-phase grant.
- `gntpar`  out  1  odd parity of `gnt`, equal to `~gnt`.
- `addr`  in  `ADDR_WIDTH`  byte address.
- `we`  in  1  1 = write, 0 = read.
- `be`  in  `DATA_WIDTH/8`  byte enables.
- `wdata`  in  `DATA_WIDTH`  write data.
- `aid`  in  `ID_WIDTH`  transaction ID.
- `rvalid`  out  1  response valid.
- `rvalidpar`  out  1  equal to `~rvalid`.
- `rready`  in  1  response accept.
- `rdata`  out  `DATA_WIDTH`  read data; 0 for writes and errored accesses.
- `err`  out  1  response error.
- `rid`  out  `ID_WIDTH`  echo of the accepted `aid`.
- `exokay`  out  1  tied to 0.

## Operation
- **Word index:** `addr >> log2(DATA_WIDTH/8)`. The low address bits are ignored.
- **In range:** an access is in range when the index is less than `MEM_DEPTH`.
- **Grant:** `gnt = (count < OUTSTANDING)`, where `count` is the FIFO occupancy. It is combinational from registered state only and does not depend on `req`.
- **Accept:** a transaction is accepted at a rising edge where `req & gnt` is true.
- **Write accept, in range:** for each byte `i` with `be[i]=1`, `mem[idx]` byte `i` is updated at the accept edge. The pushed entry is `{err=0, rdata=0, rid=aid}`.
- **Read accept, in range:** the pushed entry is `{err=0, rdata=mem[idx], rid=aid}`. Read data is taken before any same-edge write; only one transaction can be accepted per edge, so there is no same-edge conflict.
- **Out of range:** there is no memory effect. The pushed entry is `{err=1, rdata=0, rid=aid}`.
- **Response FIFO:** circular, with `OUTSTANDING` entries.
  - Push on accept; pop on `rvalid & rready`.
  - `rvalid = (count != 0)`; `rdata`, `err` and `rid` drive the head entry.
  - Push and pop in the same cycle are legal when `0 < count < OUTSTANDING`; `count` is then unchanged.
  - When `count == OUTSTANDING`, `gnt=0`, so no push occurs. A pop in that cycle frees a slot, and `gnt` rises the following cycle. There is no combinational pass-through.
  - Pointers wrap modulo `OUTSTANDING`.
- **Ordering:** responses are returned strictly in acceptance order.
- **Reset:**
  - Pointers and `count` clear to 0.
  - Outputs during and after reset: `gnt=1`, `gntpar=0`, `rvalid=0`, `rvalidpar=1`, `rdata=0`, `err=0`, `rid=0`, `exokay=0`.
  - The memory array is not reset and keeps its contents.
  - Reset asserted mid-transaction discards all pending responses immediately (asynchronously).

## Timing
- Minimum latency: accept edge N, then `rvalid=1` from N+1.
- A response retires at the first edge with `rvalid & rready`.
- Sustained throughput with `rready=1`: one transaction per cycle.
- While `rvalid=1 & rready=0`, `rdata`/`err`/`rid` must stay stable until the handshake completes.
- `gnt` falls in the cycle after the accept that makes `count == OUTSTANDING`.
- A write is visible to any read accepted at a later edge, including N+1.

## Test plan
- **Reset values:** hold `reset_n=0` for 3 cycles with `req=1` → `gnt=1`, `rvalid=0`, `rvalidpar=1`, no FIFO push, no memory write.
- **Write then read:** write `addr=0x10`, `wdata=0xDEADBEEF`, `be=4'hF`, `aid=1`, then read `0x10` with `aid=0` and `rready=1` → write response `rvalid` at N+1 with `rdata=0`, `err=0`, `rid=1`; read response at N+2 with `rdata=0xDEADBEEF`, `rid=0`.
- **Byte-enable write:** with `0x11223344` at word 4, write `addr=0x10`, `wdata=0xAABBCCDD`, `be=4'b0101` → a subsequent read returns `0x11BB33DD`.
- **Back-pressure (`OUTSTANDING=2`):** `rready=0`, three back-to-back reads → two accepted, then `gnt=0` and the third is held with `req=1`. Raising `rready` for one cycle → `gnt=1` the next cycle, third accepted, responses in order.
- **Out of range:** read and write at word index `MEM_DEPTH` (`addr=0x1000` for the defaults) → `err=1`, `rdata=0`; memory word 0 is unchanged (no aliasing).
- **Reset mid-operation:** 2 responses pending with `rready=0`, pulse `reset_n` low mid-cycle → `rvalid=0` immediately and `gnt=1` after release. Data written before reset still reads back.
